// File: rtl/calculator_alu_if.sv
// rtl/calculator_alu_if.sv - keypad-side strobes and display-side result bundle for calculator_alu
interface calculator_alu_if #(
  parameter int N = 8
);
  logic signed [N-1:0]   number_in;
  logic                  load;
  logic [1:0]            op_sel;
  logic                  op;
  logic                  equal;
  logic                  clear;
  logic signed [2*N-1:0] result;
  logic                  ready;
  logic                  busy;
  logic                  ovf;

  modport master (
    output number_in, load, op_sel, op, equal, clear,
    input  result, ready, busy, ovf
  );

  modport slave (
    input  number_in, load, op_sel, op, equal, clear,
    output result, ready, busy, ovf
  );
endinterface

// File: rtl/calculator_alu.sv
// rtl/calculator_alu.sv - sequential signed calculator: add/sub in one cycle, multiply by radix-2 Booth
module calculator_alu #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  calculator_alu_if.slave  bus
);
  typedef enum logic [2:0] {S_A, S_OP, S_B, S_EQ, S_CALC, S_DONE} state_t;

  // Booth register: {upper (2N+1), multiplier (N), q_-1}; upper carries one guard bit
  // so a chained most-negative multiplicand can still be negated without wrapping.
  localparam int PW = 3 * N + 2;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t              state_q, state_d;
  logic [2*N-1:0]      acc_q, acc_d;
  logic [N-1:0]        b_q, b_d;
  logic [1:0]          code_q, code_d;
  logic [2*N-1:0]      result_q, result_d;
  logic                ovf_q, ovf_d;
  logic [PW-1:0]       prod_q, prod_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [2*N-1:0]      num_ext, b_ext;
  logic [2*N:0]        sum_w, m_ext, upper, upper_new;
  logic [PW-1:0]       step, prod_init;
  logic                add_ovf, mul_ovf;
  logic                op_valid;

  // Shared datapath: sign extensions, add/sub with guard bit, one Booth step
  always_comb begin
    num_ext   = {{N{bus.number_in[N-1]}}, bus.number_in};
    b_ext     = {{N{b_q[N-1]}}, b_q};
    if (code_q == OP_SUB) sum_w = {acc_q[2*N-1], acc_q} - {b_ext[2*N-1], b_ext};
    else                  sum_w = {acc_q[2*N-1], acc_q} + {b_ext[2*N-1], b_ext};
    add_ovf   = sum_w[2*N] ^ sum_w[2*N-1];
    m_ext     = {acc_q[2*N-1], acc_q};
    upper     = prod_q[PW-1 -: 2*N+1];
    case (prod_q[1:0])
      2'b01:   upper_new = upper + m_ext;
      2'b10:   upper_new = upper - m_ext;
      default: upper_new = upper;
    endcase
    step      = {upper_new[2*N], upper_new, prod_q[N:1]};
    // product bit k sits at step[k+1]; overflow when product[3N-1:2N-1] is not a pure sign run
    mul_ovf   = !((&step[3*N:2*N]) || !(|step[3*N:2*N]));
    prod_init = {{(2*N+1){1'b0}}, b_q, 1'b0};
    op_valid  = bus.op && (bus.op_sel != OP_RSV);
  end

  // Next-state logic; strobe priority is clear > equal > op > load in every state
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    code_d   = code_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    if (bus.clear) begin
      state_d  = S_A;
      acc_d    = '0;
      b_d      = '0;
      code_d   = OP_ADD;
      result_d = '0;
      ovf_d    = 1'b0;
      prod_d   = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_A: begin
          if (!bus.equal && !bus.op && bus.load) begin
            acc_d   = num_ext;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (bus.equal) begin
            state_d = S_OP;
          end else if (bus.op) begin
            if (op_valid) begin
              code_d  = bus.op_sel;
              state_d = S_B;
            end
          end else if (bus.load) begin
            acc_d = num_ext;
          end
        end
        S_B: begin
          if (!bus.equal && !bus.op && bus.load) begin
            b_d     = bus.number_in;
            state_d = S_EQ;
          end
        end
        S_EQ: begin
          if (bus.equal) begin
            prod_d  = prod_init;
            cnt_d   = '0;
            state_d = S_CALC;
          end else if (bus.op) begin
            if (op_valid) code_d = bus.op_sel;
          end else if (bus.load) begin
            b_d = bus.number_in;
          end
        end
        S_CALC: begin
          if (code_q == OP_MUL) begin
            prod_d = step;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
              result_d = step[2*N:1];
              ovf_d    = ovf_q | mul_ovf;
              state_d  = S_DONE;
            end
          end else begin
            result_d = sum_w[2*N-1:0];
            ovf_d    = ovf_q | add_ovf;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.equal) begin
            acc_d   = result_q;
            prod_d  = prod_init;
            cnt_d   = '0;
            state_d = S_CALC;
          end else if (bus.op) begin
            if (op_valid) begin
              acc_d   = result_q;
              code_d  = bus.op_sel;
              state_d = S_B;
            end
          end else if (bus.load) begin
            acc_d   = num_ext;
            ovf_d   = 1'b0;
            state_d = S_OP;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  // State register; reset discards any partial Booth product
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_A;
      acc_q    <= '0;
      b_q      <= '0;
      code_q   <= OP_ADD;
      result_q <= '0;
      ovf_q    <= 1'b0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      code_q   <= code_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = (state_q == S_DONE);
  assign bus.busy   = (state_q == S_CALC);
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_calculator_alu.sv
// tb/tb_calculator_alu.sv - directed self-checking bench for calculator_alu with N=8
module tb_calculator_alu;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  calculator_alu_if #(.N(8)) bus ();

  calculator_alu #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_load(input int v);
    @(negedge clk);
    bus.number_in = 8'(v);
    bus.load = 1'b1;
    @(posedge clk);
    #1 bus.load = 1'b0;
  endtask

  task automatic pulse_op(input logic [1:0] c);
    @(negedge clk);
    bus.op_sel = c;
    bus.op = 1'b1;
    @(posedge clk);
    #1 bus.op = 1'b0;
  endtask

  task automatic pulse_equal();
    @(negedge clk);
    bus.equal = 1'b1;
    @(posedge clk);
    #1 bus.equal = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;
  endtask

  // latency counts edges from the one sampling equal; -1 means ready never came
  task automatic run_calc(output int lat, output int busy_cyc);
    int edges;
    pulse_equal();
    edges = 0;
    busy_cyc = bus.busy ? 1 : 0;
    while (!bus.ready && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.busy) busy_cyc++;
    end
    lat = bus.ready ? edges + 1 : -1;
  endtask

  task automatic test_reset();
    int lat, bc;
    rst = 1'b0;
    #12;
    n_cmp++; if (bus.result !== 16'sd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", bus.result); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
    @(negedge clk); rst = 1'b1;
    pulse_load(9); pulse_op(2'b10); pulse_load(9); pulse_equal();
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midmul_busy: got %b expected 1", bus.busy); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL async_reset_ready: got %b expected 0", bus.ready); end
    n_cmp++; if (bus.result !== 16'sd0) begin n_fail++; $display("FAIL async_reset_result: got %0d expected 0", bus.result); end
    @(negedge clk); rst = 1'b1;
    pulse_load(5); pulse_op(2'b10); pulse_load(3);
    run_calc(lat, bc);
    n_cmp++; if (bus.result !== 16'sd15) begin n_fail++; $display("FAIL mul_5x3: got %0d expected 15", bus.result); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL mul_5x3_ovf: got %b expected 0", bus.ovf); end
    n_cmp++; if (lat != 9) begin n_fail++; $display("FAIL mul_latency: got %0d expected 9", lat); end
    n_cmp++; if (bc != 8) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected 8", bc); end
  endtask

  task automatic test_signed_mul();
    int a[3] = '{-128, 7, -6};
    int b[3] = '{-128, -4, -6};
    int p[3] = '{16384, -28, 36};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      pulse_load(a[i]); pulse_op(2'b10); pulse_load(b[i]);
      run_calc(lat, bc);
      n_cmp++; if (bus.result !== 16'(p[i])) begin n_fail++; $display("FAIL signed_mul_%0d: got %0d expected %0d", i, bus.result, p[i]); end
      n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL signed_mul_ovf_%0d: got %b expected 0", i, bus.ovf); end
      n_cmp++; if (lat != 9) begin n_fail++; $display("FAIL signed_mul_lat_%0d: got %0d expected 9", i, lat); end
    end
  endtask

  task automatic test_chain_mul();
    int lat, bc;
    pulse_load(100); pulse_op(2'b10); pulse_load(100);
    run_calc(lat, bc);
    n_cmp++; if (bus.result !== 16'sd10000) begin n_fail++; $display("FAIL chain_mul_1: got %0d expected 10000", bus.result); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL chain_mul_1_ovf: got %b expected 0", bus.ovf); end
    pulse_op(2'b10);
    n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL chain_op_ready: got %b expected 0", bus.ready); end
    pulse_load(100);
    run_calc(lat, bc);
    n_cmp++; if (bus.result !== 16'sd16960) begin n_fail++; $display("FAIL chain_mul_2: got %0d expected 16960", bus.result); end
    n_cmp++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL chain_mul_2_ovf: got %b expected 1", bus.ovf); end
    pulse_load(1);
    n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL newchain_ovf_clear: got %b expected 0", bus.ovf); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL newchain_ready: got %b expected 0", bus.ready); end
  endtask

  task automatic test_addsub();
    int lat, bc;
    pulse_clear();
    pulse_load(127); pulse_op(2'b00); pulse_load(127);
    run_calc(lat, bc);
    n_cmp++; if (bus.result !== 16'sd254) begin n_fail++; $display("FAIL add_127: got %0d expected 254", bus.result); end
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", lat); end
    n_cmp++; if (bc != 1) begin n_fail++; $display("FAIL add_busy_cycles: got %0d expected 1", bc); end
    pulse_op(2'b01); pulse_load(-128);
    run_calc(lat, bc);
    n_cmp++; if (bus.result !== 16'sd382) begin n_fail++; $display("FAIL sub_chain: got %0d expected 382", bus.result); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL sub_chain_ovf: got %b expected 0", bus.ovf); end
    run_calc(lat, bc);
    n_cmp++; if (bus.result !== 16'sd510) begin n_fail++; $display("FAIL repeat_equal: got %0d expected 510", bus.result); end
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL repeat_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_priority();
    int lat, bc;
    pulse_clear();
    pulse_load(9);
    pulse_op(2'b11);
    pulse_load(20);
    pulse_op(2'b01);
    pulse_equal();
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL equal_in_sb_busy: got %b expected 0", bus.busy); end
    pulse_load(4);
    run_calc(lat, bc);
    n_cmp++; if (bus.result !== 16'sd16) begin n_fail++; $display("FAIL reserved_op_ignored: got %0d expected 16", bus.result); end
    @(negedge clk);
    bus.clear = 1'b1;
    bus.equal = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0; bus.equal = 1'b0;
    n_cmp++; if (bus.result !== 16'sd0) begin n_fail++; $display("FAIL clear_beats_equal_result: got %0d expected 0", bus.result); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clear_beats_equal_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL clear_beats_equal_ready: got %b expected 0", bus.ready); end
  endtask

  task automatic test_clear_mid_mul();
    int lat, bc;
    pulse_load(7); pulse_op(2'b10); pulse_load(5); pulse_equal();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL pre_clear_busy: got %b expected 1", bus.busy); end
    pulse_clear();
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clear_mid_busy: got %b expected 0", bus.busy); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL clear_mid_ready: got %b expected 0", bus.ready); end
    n_cmp++; if (bus.result !== 16'sd0) begin n_fail++; $display("FAIL clear_mid_result: got %0d expected 0", bus.result); end
    pulse_equal();
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL equal_in_sa_busy: got %b expected 0", bus.busy); end
    pulse_load(2); pulse_op(2'b10); pulse_load(3);
    run_calc(lat, bc);
    n_cmp++; if (bus.result !== 16'sd6) begin n_fail++; $display("FAIL fresh_2x3: got %0d expected 6", bus.result); end
    n_cmp++; if (lat != 9) begin n_fail++; $display("FAIL fresh_2x3_latency: got %0d expected 9", lat); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.number_in = '0;
    bus.load = 1'b0;
    bus.op_sel = 2'b00;
    bus.op = 1'b0;
    bus.equal = 1'b0;
    bus.clear = 1'b0;
    test_reset();
    test_signed_mul();
    test_chain_mul();
    test_addsub();
    test_priority();
    test_clear_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
